linear_feedback_shift_register_5b: RTL and testbench
====================================================

// Module: linear_feedback_shift_register_5b
// PURPOSE
//   5-bit maximal-length Fibonacci LFSR.
//   - Polynomial x^5 + x^3 + 1; period 31, visits every non-zero 5-bit value once.
//   - Free-running pseudo-random source for the player datapath (test patterns, dither).
//   - Also provides a serial output bit, a step counter and a once-per-period marker.
// PARAMETERS
//   SEED   5'b00001  reset/reload value of lfsr; must be non-zero (elaboration $error if 0)
// PORTS
//   clk           input   1  single clock, all state updates on rising edge
//   reset         input   1  asynchronous, active-low reset (0 = reset asserted)
//   lfsr          output  5  current LFSR state, registered
//   bit_out       output  1  serial output = lfsr[4], combinational from register
//   step_count    output  5  shifts since last period start, 0..30, registered
//   period_done   output  1  one-cycle pulse on each wrap back to SEED, registered
// BEHAVIOUR
//   Reset:
//   - reset==0 asynchronously forces lfsr=SEED, step_count=0, period_done=0.
//   - Outputs hold these values while reset stays low.
//   - Reset asserted mid-sequence aborts the sequence immediately; no partial update.
//   Stepping:
//   - One shift per rising clk while reset==1; no enable, never stalls.
//   - First shift occurs on the first rising edge after reset deasserts.
//   - fb = lfsr[4] ^ lfsr[2].
//   - Next state: lfsr <= {lfsr[3:0], fb} (shift toward MSB, feedback into bit 0).
//   Sequence from SEED=00001:
//     00001, 00010, 00100, 01001, 10010, 00101, 01011, 10110, ...
//   - Returns to 00001 after exactly 31 shifts.
//   Lock-up guard:
//   - If lfsr ever holds 5'b00000 (e.g. SEU), the next edge loads SEED, not 0.
//   - During that guard edge, step_count resets to 0 and period_done stays 0.
//   Step counter:
//   - step_count increments each shift.
//   - Wraps 30 -> 0 on the same edge that lfsr returns to SEED.
//   Period marker:
//   - period_done=1 for exactly the one cycle in which lfsr==SEED and step_count==0
//     following a wrap, i.e. cycles 31, 62, ... after reset release.
//   - period_done is 0 in the first cycle after reset.
//   Timing:
//   - All outputs change only on clk rising edge or on reset assertion.
//   - Zero-cycle combinational paths from inputs to outputs: none.
// TESTING
//   1. reset=0 for 2 cycles -> lfsr=00001, step_count=0, period_done=0, bit_out=0 throughout.
//   2. Release reset, 7 edges -> lfsr=00010,00100,01001,10010,00101,01011,10110.
//   3. Run 31 edges -> all 31 non-zero values seen exactly once, 00000 never seen.
//      After the 31st edge lfsr=00001, step_count=0, period_done=1 for one cycle.
//   4. Run 40 cycles at 10 ns period -> period_done pulses exactly once;
//      step_count reads 9 at the end.
//   5. Assert reset between edges mid-sequence -> lfsr=00001 immediately, without a clock edge.
//      After release the sequence restarts at 00010.
//   6. Force lfsr=00000 via hierarchical deposit -> next edge gives lfsr=00001,
//      step_count=0, period_done=0.

Source files
------------

// File: rtl/linear_feedback_shift_register_5b_if.sv
// ---------------------------------------------------------------------------
// linear_feedback_shift_register_5b_if
//   Output bundle of the 5-bit LFSR. The LFSR drives it through the master
//   modport, and consumers read it through the slave modport.
//   lfsr         5  current LFSR state
//   bit_out      1  serial output bit (lfsr[4])
//   step_count   5  shifts since the start of the current period, 0..30
//   period_done  1  one-cycle pulse when the state wraps back to SEED
// ---------------------------------------------------------------------------
interface linear_feedback_shift_register_5b_if;
    logic [4:0] lfsr;
    logic       bit_out;
    logic [4:0] step_count;
    logic       period_done;

    modport master (
        output lfsr,
        output bit_out,
        output step_count,
        output period_done
    );

    modport slave (
        input lfsr,
        input bit_out,
        input step_count,
        input period_done
    );
endinterface

// File: rtl/linear_feedback_shift_register_5b.sv
// ---------------------------------------------------------------------------
// linear_feedback_shift_register_5b
//   Free-running 5-bit maximal-length Fibonacci LFSR, x^5 + x^3 + 1,
//   with period 31. It steps once on every rising clock edge while out of
//   reset and also provides a step counter and a once-per-period marker.
//   clk     in   single clock, rising edge
//   reset   in   asynchronous, active-low reset
//   bus     out  master modport: lfsr, bit_out, step_count, period_done
// ---------------------------------------------------------------------------
module linear_feedback_shift_register_5b #(
    parameter logic [4:0] SEED = 5'b00001
) (
    input  logic                                   clk,
    input  logic                                   reset,
    linear_feedback_shift_register_5b_if.master    bus
);

    // An all-zero seed would sit in the lock-up state forever.
    if (SEED == 5'd0) begin : g_bad_seed
        $error("linear_feedback_shift_register_5b: SEED must be non-zero");
    end

    localparam logic [4:0] LAST_STEP = 5'd30;

    logic [4:0] r_lfsr;
    logic [4:0] r_step;
    logic       r_done;

    logic       w_fb;
    logic [4:0] w_next;
    logic       w_locked;
    logic       w_wrap;

    assign w_fb     = r_lfsr[4] ^ r_lfsr[2];
    assign w_next   = {r_lfsr[3:0], w_fb};
    assign w_locked = (r_lfsr == 5'd0);
    // Step 30 is the last state before the sequence returns to SEED.
    assign w_wrap   = (r_step == LAST_STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
            r_step <= 5'd0;
            r_done <= 1'b0;
        end else if (w_locked) begin
            // The all-zero state cannot leave by shifting. Restart the
            // period cleanly from SEED, and do not report that restart as a
            // period completion.
            r_lfsr <= SEED;
            r_step <= 5'd0;
            r_done <= 1'b0;
        end else begin
            r_lfsr <= w_next;
            r_step <= w_wrap ? 5'd0 : r_step + 5'd1;
            r_done <= w_wrap;
        end
    end

    assign bus.lfsr        = r_lfsr;
    assign bus.bit_out     = r_lfsr[4];
    assign bus.step_count  = r_step;
    assign bus.period_done = r_done;

endmodule

// File: tb/tb_linear_feedback_shift_register_5b.sv
module tb_linear_feedback_shift_register_5b;

    localparam logic [4:0] SEED = 5'b00001;

    logic clk;
    logic reset;

    linear_feedback_shift_register_5b_if bus ();

    linear_feedback_shift_register_5b #(.SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference: the whole period is listed once from the polynomial
    // recurrence. After k shifts from SEED the state is seq[k mod 31], the
    // step count is k mod 31, and the marker is set when k is a non-zero
    // multiple of 31.
    logic [4:0] seq [31];
    int         k;

    function automatic logic [4:0] poly_step(input logic [4:0] v);
        int t;
        t = ((v >> 4) + (v >> 2)) % 2;        // taps of x^5 + x^3 + 1
        return 5'((int'(v) * 2) % 32 + t);
    endfunction

    typedef struct {
        logic [4:0] lfsr;
        logic [4:0] step;
        logic       done;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [4:0] e_lfsr,
                             input logic [4:0] e_step, input logic e_done);
        check({name, ".lfsr"}, bus.lfsr, e_lfsr);
        check({name, ".step"}, bus.step_count, e_step);
        check({name, ".done"}, {4'd0, bus.period_done}, {4'd0, e_done});
        check({name, ".bit"},  {4'd0, bus.bit_out}, {4'd0, e_lfsr[4]});
    endtask

    task automatic check_model(input string name);
        check_all(name, seq[k % 31], 5'(k % 31), (k > 0) && (k % 31 == 0));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        k++;
    endtask

    int seen [32];
    int pulses;
    bit found;

    initial begin
        n_vec = 0;
        n_err = 0;
        k     = 0;

        seq[0] = SEED;
        for (int i = 1; i < 31; i++) seq[i] = poly_step(seq[i-1]);

        tbl[0] = '{5'b00010, 5'd1, 1'b0};
        tbl[1] = '{5'b00100, 5'd2, 1'b0};
        tbl[2] = '{5'b01001, 5'd3, 1'b0};
        tbl[3] = '{5'b10010, 5'd4, 1'b0};
        tbl[4] = '{5'b00101, 5'd5, 1'b0};
        tbl[5] = '{5'b01011, 5'd6, 1'b0};
        tbl[6] = '{5'b10110, 5'd7, 1'b0};

        // Held reset: the outputs stay at their reset values across edges.
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_all("reset_hold", SEED, 5'd0, 1'b0);
        end

        // Release between edges, then walk the known opening of the sequence.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("post_release", SEED, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) seen[i] = 0;
        for (int i = 0; i < 7; i++) begin
            edge_step();
            check_all($sformatf("tbl%0d", i), tbl[i].lfsr, tbl[i].step, tbl[i].done);
            seen[bus.lfsr]++;
        end

        // Finish one full period and confirm it is a permutation of 1..31.
        for (int i = 7; i < 31; i++) begin
            edge_step();
            check_model($sformatf("period_e%0d", k));
            seen[bus.lfsr]++;
        end
        check("never_zero", 5'(seen[0]), 5'd0);
        for (int v = 1; v < 32; v++) check($sformatf("seen_%0d", v), 5'(seen[v]), 5'd1);
        check_all("wrap", SEED, 5'd0, 1'b1);
        edge_step();
        check_all("after_wrap", 5'b00010, 5'd1, 1'b0);

        // Over 40 cycles from a fresh reset there is exactly one period pulse.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            edge_step();
            if (bus.period_done) pulses++;
        end
        check("pulse_count_40", 5'(pulses), 5'd1);
        check("step_at_40", bus.step_count, 5'd9);

        // Reset asserted between edges must take effect without a clock.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", SEED, 5'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        edge_step();
        check_all("restart", 5'b00010, 5'd1, 1'b0);

        // Lock-up guard: corrupt the state to zero on the wrap cycle.
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus.step_count == 5'd30) found = 1'b1;
            else edge_step();
        end
        check("reach_step30", {4'd0, found}, 5'd1);
        @(negedge clk);
        force dut.r_lfsr = 5'd0;
        #1;
        release dut.r_lfsr;
        #1;
        check("forced_zero", bus.lfsr, 5'd0);
        @(posedge clk);
        #1;
        check_all("lockup_guard", SEED, 5'd0, 1'b0);
        k = 0;

        // Randomised run with occasional asynchronous resets between edges.
        for (int c = 0; c < 400; c++) begin
            edge_step();
            check_model($sformatf("rand_c%0d", c));
            if ($urandom_range(0, 99) < 4) begin
                #($urandom_range(1, 3));
                reset = 1'b0;
                #1;
                check_all("rand_async_reset", SEED, 5'd0, 1'b0);
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                    check_all("rand_reset_held", SEED, 5'd0, 1'b0);
                    @(negedge clk);
                end
                reset = 1'b1;
                k = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
